// File: rtl/dbus_bridge_pkg.sv
// dbus_bridge_pkg: widths, memory-stage operation codes, FSM states and store-lane helpers.
package dbus_bridge_pkg;
    localparam int W_ADDR = 32;
    localparam int W_DATA = 32;
    localparam int W_OPER = 4;
    localparam logic [W_OPER-1:0] OPER_LB  = 4'd1;
    localparam logic [W_OPER-1:0] OPER_LBU = 4'd2;
    localparam logic [W_OPER-1:0] OPER_LH  = 4'd3;
    localparam logic [W_OPER-1:0] OPER_LHU = 4'd4;
    localparam logic [W_OPER-1:0] OPER_LW  = 4'd5;
    localparam logic [W_OPER-1:0] OPER_SB  = 4'd6;
    localparam logic [W_OPER-1:0] OPER_SH  = 4'd7;
    localparam logic [W_OPER-1:0] OPER_SW  = 4'd8;
    typedef enum logic [2:0] {ST_IDLE, ST_REQ, ST_WAIT, ST_DONE, ST_CANCEL} state_e;
    // Halfwords only honour addr[1]; words ignore both low bits.
    function automatic logic [3:0] lane_be(input logic [3:0] we, input logic [1:0] off);
        return we == 4'b0001 ? we << off : we == 4'b0011 ? we << {off[1], 1'b0} : we;
    endfunction
    function automatic logic [W_DATA-1:0] lane_wdata(input logic [3:0] we, input logic [W_DATA-1:0] d);
        return we == 4'b0001 ? {4{d[7:0]}} : we == 4'b0011 ? {2{d[15:0]}} : d;
    endfunction
endpackage

// File: rtl/dbus_bridge_if.sv
// dbus_bridge_if: SRAM-like memory port; the bridge is master, the memory is slave.
interface dbus_bridge_if;
    import dbus_bridge_pkg::*;
    logic              mem_req;
    logic              mem_wr;
    logic [3:0]        mem_be;
    logic [W_ADDR-1:0] mem_addr;
    logic [W_DATA-1:0] mem_wdata;
    logic              mem_addr_ok;
    logic              mem_data_ok;
    logic [W_DATA-1:0] mem_rdata;
    modport master (output mem_req, mem_wr, mem_be, mem_addr, mem_wdata,
                    input  mem_addr_ok, mem_data_ok, mem_rdata);
    modport slave  (input  mem_req, mem_wr, mem_be, mem_addr, mem_wdata,
                    output mem_addr_ok, mem_data_ok, mem_rdata);
endinterface

// File: rtl/dbus_bridge_load_ext.sv
// dbus_bridge_load_ext: selects the addressed byte/halfword of read data and sign/zero-extends it.
module dbus_bridge_load_ext
    import dbus_bridge_pkg::*;
(
    input  logic [W_OPER-1:0] oper,
    input  logic [1:0]        addr,
    input  logic [W_DATA-1:0] rdata,
    output logic [W_DATA-1:0] data_o
);
    logic [7:0]  b;
    logic [15:0] h;
    always_comb begin
        b = addr[1] ? (addr[0] ? rdata[31:24] : rdata[23:16]) : (addr[0] ? rdata[15:8] : rdata[7:0]);
        h = addr[1] ? rdata[31:16] : rdata[15:0];
        data_o = oper == OPER_LB  ? {{24{b[7]}}, b} :
                 oper == OPER_LBU ? {24'd0, b} :
                 oper == OPER_LH  ? {{16{h[15]}}, h} :
                 oper == OPER_LHU ? {16'd0, h} : rdata;
    end
endmodule

// File: rtl/dbus_bridge.sv
// dbus_bridge: runs single-cycle dbus requests as multi-cycle memory-port transactions.
// Define DBUS_ALIGN_CHECK_EN to add adel/ades misaligned-access outputs.
module dbus_bridge
    import dbus_bridge_pkg::*;
(
    input  logic              clk,
    input  logic              rst,
    input  logic              flush,
    input  logic [W_OPER-1:0] oper,
    input  logic              dbus_en,
    input  logic [3:0]        dbus_we,
    input  logic [W_ADDR-1:0] dbus_addr,
    input  logic [W_DATA-1:0] dbus_data,
    output logic              stall,
    output logic [W_DATA-1:0] load_data,
`ifdef DBUS_ALIGN_CHECK_EN
    output logic              adel,
    output logic              ades,
`endif
    dbus_bridge_if.master     mem
);
    state_e            state_q, state_d;
    logic [W_OPER-1:0] oper_q, oper_d;
    logic [1:0]        off_q, off_d;
    logic              req_q, req_d, wr_q, wr_d;
    logic [3:0]        be_q, be_d;
    logic [W_ADDR-1:0] addr_q, addr_d;
    logic [W_DATA-1:0] wdata_q, wdata_d, load_q, load_d, ext;
    logic              accept, misalign;
`ifdef DBUS_ALIGN_CHECK_EN
    logic half_op, word_op, store_op;
    assign half_op  = oper inside {OPER_LH, OPER_LHU, OPER_SH};
    assign word_op  = oper inside {OPER_LW, OPER_SW};
    assign store_op = oper inside {OPER_SH, OPER_SW};
    assign misalign = dbus_en && !flush && state_q == ST_IDLE &&
                      ((half_op && dbus_addr[0]) || (word_op && dbus_addr[1:0] != 2'b00));
    assign adel = misalign && !store_op;
    assign ades = misalign && store_op;
`else
    assign misalign = 1'b0;
`endif
    assign accept = state_q == ST_IDLE && dbus_en && !flush && !misalign;
    dbus_bridge_load_ext u_load_ext (.oper(oper_q), .addr(off_q), .rdata(mem.mem_rdata), .data_o(ext));
    always_comb begin
        oper_d  = accept ? oper : oper_q;
        off_d   = accept ? dbus_addr[1:0] : off_q;
        wr_d    = accept ? |dbus_we : wr_q;
        be_d    = accept ? lane_be(dbus_we, dbus_addr[1:0]) : be_q;
        addr_d  = accept ? {dbus_addr[W_ADDR-1:2], 2'b00} : addr_q;
        wdata_d = accept ? lane_wdata(dbus_we, dbus_data) : wdata_q;
        state_d = state_q;
        // A flush that coincides with the read data simply drops it and returns to IDLE.
        case (state_q)
            ST_IDLE:   state_d = accept ? ST_REQ : ST_IDLE;
            ST_REQ:    state_d = !mem.mem_addr_ok ? (flush ? ST_IDLE : ST_REQ) :
                                 mem.mem_data_ok ? (flush ? ST_IDLE : ST_DONE) :
                                 (flush ? ST_CANCEL : ST_WAIT);
            ST_WAIT:   state_d = mem.mem_data_ok ? (flush ? ST_IDLE : ST_DONE) :
                                 (flush ? ST_CANCEL : ST_WAIT);
            ST_DONE:   state_d = ST_IDLE;
            ST_CANCEL: state_d = mem.mem_data_ok ? ST_IDLE : ST_CANCEL;
            default:   state_d = ST_IDLE;
        endcase
        req_d  = state_d == ST_REQ;
        load_d = state_d == ST_DONE ? ext : load_q;
        stall  = accept || state_q == ST_REQ || state_q == ST_WAIT || (state_q == ST_CANCEL && dbus_en);
    end
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= ST_IDLE;
            oper_q  <= '0;
            off_q   <= '0;
            req_q   <= 1'b0;
            wr_q    <= 1'b0;
            be_q    <= '0;
            addr_q  <= '0;
            wdata_q <= '0;
            load_q  <= '0;
        end else begin
            state_q <= state_d;
            oper_q  <= oper_d;
            off_q   <= off_d;
            req_q   <= req_d;
            wr_q    <= wr_d;
            be_q    <= be_d;
            addr_q  <= addr_d;
            wdata_q <= wdata_d;
            load_q  <= load_d;
        end
    end
    assign mem.mem_req   = req_q;
    assign mem.mem_wr    = wr_q;
    assign mem.mem_be    = be_q;
    assign mem.mem_addr  = addr_q;
    assign mem.mem_wdata = wdata_q;
    assign load_data     = load_q;
endmodule

// File: tb/tb_dbus_bridge.sv
// tb_dbus_bridge: vector table, randomized transactions against a behavioural model,
// and hand-written flush/cancel/reset sequences for dbus_bridge.
`timescale 1ns/1ps
module tb_dbus_bridge;
    import dbus_bridge_pkg::*;
    logic              clk = 1'b0;
    logic              rst = 1'b1;
    logic              flush = 1'b0;
    logic              dbus_en = 1'b0;
    logic [W_OPER-1:0] oper = '0;
    logic [3:0]        dbus_we = '0;
    logic [W_ADDR-1:0] dbus_addr = '0;
    logic [W_DATA-1:0] dbus_data = '0;
    logic              stall;
    logic [W_DATA-1:0] load_data;
`ifdef DBUS_ALIGN_CHECK_EN
    logic              adel, ades;
`endif
    int n_chk = 0;
    int n_pass = 0;
    dbus_bridge_if mif();
    dbus_bridge dut (
        .clk(clk), .rst(rst), .flush(flush), .oper(oper), .dbus_en(dbus_en),
        .dbus_we(dbus_we), .dbus_addr(dbus_addr), .dbus_data(dbus_data),
        .stall(stall), .load_data(load_data),
`ifdef DBUS_ALIGN_CHECK_EN
        .adel(adel), .ades(ades),
`endif
        .mem(mif)
    );
    always #5 clk = ~clk;
    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not reach its summary");
        $fatal(1);
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h", name, act, exp);
    endtask

    function automatic bit is_store(input logic [3:0] op);
        return op == OPER_SB || op == OPER_SH || op == OPER_SW;
    endfunction
    function automatic int size_of(input logic [3:0] op);
        return (op == OPER_LB || op == OPER_LBU || op == OPER_SB) ? 1 :
               (op == OPER_LH || op == OPER_LHU || op == OPER_SH) ? 2 : 4;
    endfunction
    function automatic logic [3:0] m_we(input logic [3:0] op);
        return !is_store(op) ? 4'b0000 : size_of(op) == 1 ? 4'b0001 : size_of(op) == 2 ? 4'b0011 : 4'b1111;
    endfunction
    function automatic int m_lane(input logic [3:0] op, input logic [31:0] addr);
        return int'(addr[1:0]) / size_of(op) * size_of(op);
    endfunction
    function automatic logic [3:0] m_be(input logic [3:0] op, input logic [31:0] addr);
        int bits;
        if (!is_store(op)) return 4'b0000;
        bits = ((1 << size_of(op)) - 1) << m_lane(op, addr);
        return bits[3:0];
    endfunction
    function automatic logic [31:0] m_wdata(input logic [3:0] op, input logic [31:0] data);
        return size_of(op) == 1 ? {24'd0, data[7:0]} * 32'h0101_0101 :
               size_of(op) == 2 ? {16'd0, data[15:0]} * 32'h0001_0001 : data;
    endfunction
    function automatic logic [31:0] m_load(input logic [3:0] op, input logic [31:0] addr, input logic [31:0] rdata);
        logic [31:0]        v;
        logic signed [31:0] r;
        v = rdata >> (8 * m_lane(op, addr));
        case (op)
            OPER_LB:  r = $signed(v[7:0]);
            OPER_LH:  r = $signed(v[15:0]);
            OPER_LBU: r = {24'd0, v[7:0]};
            OPER_LHU: r = {16'd0, v[15:0]};
            default:  r = rdata;
        endcase
        return r;
    endfunction

    task automatic do_txn(input logic [3:0] op, input logic [31:0] addr, data, rdata,
                          input int a_dly, d_dly, input logic [3:0] e_be,
                          input logic [31:0] e_wd, e_ld);
        logic [31:0] ea;
        ea = {addr[31:2], 2'b00};
        @(posedge clk); #1;
        oper = op; dbus_we = m_we(op); dbus_addr = addr; dbus_data = data; dbus_en = 1'b1;
        mif.mem_addr_ok = 1'b0; mif.mem_data_ok = 1'b0;
        @(negedge clk);
        chk("idle_stall", stall, 1);
        chk("idle_req", mif.mem_req, 0);
        for (int k = 0; k <= a_dly; k++) begin
            @(posedge clk); #1;
            mif.mem_addr_ok = k == a_dly;
            mif.mem_data_ok = k == a_dly && d_dly == 0;
            mif.mem_rdata = mif.mem_data_ok ? rdata : $urandom;
            @(negedge clk);
            chk("req", mif.mem_req, 1);
            chk("req_stall", stall, 1);
            chk("req_addr", mif.mem_addr, ea);
            chk("req_be", mif.mem_be, e_be);
            chk("req_wr", mif.mem_wr, is_store(op));
            if (is_store(op)) chk("req_wdata", mif.mem_wdata, e_wd);
        end
        for (int k = 1; k <= d_dly; k++) begin
            @(posedge clk); #1;
            mif.mem_addr_ok = 1'b0;
            mif.mem_data_ok = k == d_dly;
            mif.mem_rdata = mif.mem_data_ok ? rdata : $urandom;
            @(negedge clk);
            chk("wait_req", mif.mem_req, 0);
            chk("wait_stall", stall, 1);
        end
        @(posedge clk); #1;
        mif.mem_addr_ok = 1'b0; mif.mem_data_ok = 1'b0; mif.mem_rdata = $urandom;
        @(negedge clk);
        chk("done_stall", stall, 0);
        chk("done_req", mif.mem_req, 0);
        if (!is_store(op)) chk("load_data", load_data, e_ld);
        @(posedge clk); #1;
        dbus_en = 1'b0;
        @(negedge clk);
        chk("after_stall", stall, 0);
    endtask

    typedef struct {
        logic [3:0]  op;
        logic [31:0] addr, data, rdata;
        int          a_dly, d_dly;
        logic [3:0]  be;
        logic [31:0] wd, ld;
    } vec_t;
    vec_t tbl [9];
    logic [3:0] ops [8];

    initial begin
        tbl[0] = '{OPER_SB,  32'h1003, 32'h0000_00A5, 32'h0,         0, 1, 4'b1000, 32'hA5A5_A5A5, 32'h0};
        tbl[1] = '{OPER_LB,  32'h2002, 32'h0,         32'h12F0_5678, 0, 1, 4'b0000, 32'h0, 32'hFFFF_FFF0};
        tbl[2] = '{OPER_LBU, 32'h2002, 32'h0,         32'h12F0_5678, 0, 1, 4'b0000, 32'h0, 32'h0000_00F0};
        tbl[3] = '{OPER_LH,  32'h2002, 32'h0,         32'h12F0_5678, 5, 1, 4'b0000, 32'h0, 32'h0000_12F0};
        tbl[4] = '{OPER_LH,  32'h2000, 32'h0,         32'h1234_8001, 1, 2, 4'b0000, 32'h0, 32'hFFFF_8001};
        tbl[5] = '{OPER_SH,  32'h1002, 32'h0000_BEEF, 32'h0,         0, 0, 4'b1100, 32'hBEEF_BEEF, 32'h0};
        tbl[6] = '{OPER_SW,  32'h1004, 32'hDEAD_BEEF, 32'h0,         2, 0, 4'b1111, 32'hDEAD_BEEF, 32'h0};
        tbl[7] = '{OPER_LW,  32'h3008, 32'h0,         32'hCAFE_F00D, 0, 0, 4'b0000, 32'h0, 32'hCAFE_F00D};
        tbl[8] = '{OPER_LHU, 32'h2002, 32'h0,         32'h8765_4321, 1, 1, 4'b0000, 32'h0, 32'h0000_8765};
        ops = '{OPER_LB, OPER_LBU, OPER_LH, OPER_LHU, OPER_LW, OPER_SB, OPER_SH, OPER_SW};
        mif.mem_addr_ok = 1'b0; mif.mem_data_ok = 1'b0; mif.mem_rdata = '0;
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        chk("rst_stall", stall, 0);
        chk("rst_req", mif.mem_req, 0);
        chk("rst_wr", mif.mem_wr, 0);
        chk("rst_be", mif.mem_be, 0);
        chk("rst_addr", mif.mem_addr, 0);
        chk("rst_wdata", mif.mem_wdata, 0);
        chk("rst_load", load_data, 0);
        for (int i = 0; i < 9; i++)
            do_txn(tbl[i].op, tbl[i].addr, tbl[i].data, tbl[i].rdata, tbl[i].a_dly, tbl[i].d_dly,
                   tbl[i].be, tbl[i].wd, tbl[i].ld);
        for (int i = 0; i < 40; i++) begin
            logic [3:0]  op;
            logic [31:0] addr, data, rdata;
            op = ops[$urandom_range(0, 7)];
            addr = $urandom; data = $urandom; rdata = $urandom;
`ifdef DBUS_ALIGN_CHECK_EN
            addr = addr & ~32'(size_of(op) - 1);
`endif
            do_txn(op, addr, data, rdata, $urandom_range(0, 3), $urandom_range(0, 3),
                   m_be(op, addr), m_wdata(op, data), m_load(op, addr, rdata));
        end
        // Flush while waiting for read data: stale data must be dropped.
        do_txn(OPER_LW, 32'h3000, 32'h0, 32'h5555_AAAA, 0, 1, 4'b0000, 32'h0, 32'h5555_AAAA);
        @(posedge clk); #1;
        oper = OPER_LW; dbus_we = 4'b0000; dbus_addr = 32'h4000; dbus_en = 1'b1;
        @(posedge clk); #1;
        mif.mem_addr_ok = 1'b1;
        @(negedge clk);
        chk("c_req", mif.mem_req, 1);
        @(posedge clk); #1;
        mif.mem_addr_ok = 1'b0; flush = 1'b1; dbus_en = 1'b0;
        @(negedge clk);
        chk("c_wait_stall", stall, 1);
        @(posedge clk); #1;
        flush = 1'b0;
        @(negedge clk);
        chk("c_cancel_stall0", stall, 0);
        chk("c_cancel_req", mif.mem_req, 0);
        @(posedge clk); #1;
        oper = OPER_SW; dbus_we = 4'b1111; dbus_addr = 32'h5000; dbus_data = 32'h1357_9BDF; dbus_en = 1'b1;
        @(negedge clk);
        chk("c_cancel_stall1", stall, 1);
        chk("c_cancel_req1", mif.mem_req, 0);
        @(posedge clk); #1;
        mif.mem_data_ok = 1'b1; mif.mem_rdata = 32'hBAD0_BAD0;
        @(negedge clk);
        chk("c_cancel_stall2", stall, 1);
        @(posedge clk); #1;
        mif.mem_data_ok = 1'b0;
        @(negedge clk);
        chk("c_idle_stall", stall, 1);
        chk("c_idle_req", mif.mem_req, 0);
        chk("c_load_kept", load_data, 32'h5555_AAAA);
        @(posedge clk); #1;
        mif.mem_addr_ok = 1'b1; mif.mem_data_ok = 1'b1;
        @(negedge clk);
        chk("c_next_req", mif.mem_req, 1);
        chk("c_next_addr", mif.mem_addr, 32'h5000);
        chk("c_next_be", mif.mem_be, 4'b1111);
        chk("c_next_wdata", mif.mem_wdata, 32'h1357_9BDF);
        @(posedge clk); #1;
        mif.mem_addr_ok = 1'b0; mif.mem_data_ok = 1'b0;
        @(negedge clk);
        chk("c_next_done", stall, 0);
        @(posedge clk); #1;
        dbus_en = 1'b0;
        // Flush before the address is accepted withdraws the request.
        @(posedge clk); #1;
        oper = OPER_LW; dbus_we = 4'b0000; dbus_addr = 32'h6000; dbus_en = 1'b1;
        @(posedge clk); #1;
        flush = 1'b1;
        @(negedge clk);
        chk("f_req_stall", stall, 1);
        chk("f_req", mif.mem_req, 1);
        @(posedge clk); #1;
        flush = 1'b0; dbus_en = 1'b0;
        @(negedge clk);
        chk("f_idle_req", mif.mem_req, 0);
        chk("f_idle_stall", stall, 0);
        @(posedge clk); #1;
        dbus_en = 1'b1; flush = 1'b1;
        @(negedge clk);
        chk("f_block_stall", stall, 0);
        @(posedge clk); #1;
        dbus_en = 1'b0; flush = 1'b0;
        @(negedge clk);
        chk("f_block_req", mif.mem_req, 0);
        // Reset in the middle of a request.
        @(posedge clk); #1;
        oper = OPER_SB; dbus_we = 4'b0001; dbus_addr = 32'h7001; dbus_data = 32'h77; dbus_en = 1'b1;
        @(posedge clk); #1;
        rst = 1'b1;
        @(negedge clk);
        chk("r_req", mif.mem_req, 1);
        chk("r_be", mif.mem_be, 4'b0010);
        @(posedge clk); #1;
        rst = 1'b0; dbus_en = 1'b0;
        @(negedge clk);
        chk("r_req0", mif.mem_req, 0);
        chk("r_stall0", stall, 0);
        chk("r_be0", mif.mem_be, 0);
`ifdef DBUS_ALIGN_CHECK_EN
        @(posedge clk); #1;
        oper = OPER_SW; dbus_we = 4'b1111; dbus_addr = 32'h3002; dbus_en = 1'b1;
        @(negedge clk);
        chk("a_ades", ades, 1);
        chk("a_adel", adel, 0);
        chk("a_stall", stall, 0);
        repeat (3) begin
            @(posedge clk); #1;
            @(negedge clk);
            chk("a_noreq", mif.mem_req, 0);
        end
        @(posedge clk); #1;
        oper = OPER_LH; dbus_we = 4'b0000; dbus_addr = 32'h2001;
        @(negedge clk);
        chk("a_adel_lh", adel, 1);
        chk("a_ades_lh", ades, 0);
        @(posedge clk); #1;
        dbus_en = 1'b0;
        @(negedge clk);
        chk("a_noreq_lh", mif.mem_req, 0);
`endif
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule

// File: doc/dbus_bridge.md
# dbus_bridge

Data-bus bridge sitting directly downstream of the memory-stage controller: it takes the single-cycle dbus request (enable, byte-write mask, address, data) plus the memory-stage operation code and runs it as a multi-cycle transaction on an SRAM-like memory port. It aligns store byte lanes, sign/zero-extends load data, and stalls the pipeline until the transaction completes or is cancelled by a flush.

## Interface
- No parameters; widths come from `W_ADDR`, `W_DATA` and `W_OPER` in defines.vh.
- clk  in  1  clock; all state updates on the rising edge
- rst  in  1  synchronous, active-high reset
- flush  in  1  exception/branch flush of the memory stage
- oper  in  `W_OPER  memory-stage operation; selects load extension
- dbus_en  in  1  request valid; held stable by the pipeline while stall=1
- dbus_we  in  4  unshifted write mask: 0001 SB, 0011 SH, 1111 SW, 0000 load
- dbus_addr  in  `W_ADDR  byte address
- dbus_data  in  `W_DATA  store data, low-aligned
- stall  out  1  hold memory stage and all earlier stages
- load_data  out  `W_DATA  extended load result; valid in DONE only
- mem_req  out  1  memory request
- mem_wr  out  1  1 = write
- mem_be  out  4  lane-aligned byte enables
- mem_addr  out  `W_ADDR  word-aligned address (low 2 bits zero)
- mem_wdata  out  `W_DATA  lane-replicated store data
- mem_addr_ok  in  1  request accepted this cycle
- mem_data_ok  in  1  write done / read data valid this cycle
- mem_rdata  in  `W_DATA  read data

## Operation
- States: IDLE, REQ, WAIT, DONE, CANCEL. Reset: IDLE; stall, mem_req, mem_wr, mem_be, mem_addr, mem_wdata, load_data all 0.
- IDLE: dbus_en=1 and flush=0 -> latch oper, addr, mask, data; go REQ. stall=dbus_en&~flush (combinational).
- REQ: mem_req=1 from latched registers. addr_ok=0 -> stay. addr_ok=1 -> WAIT; addr_ok and data_ok together -> DONE. flush with addr_ok=0 -> IDLE (request withdrawn); flush with addr_ok=1 and data_ok=0 -> CANCEL.
- WAIT: mem_req=0. data_ok=1 -> DONE, register extended rdata into load_data. flush -> CANCEL (unless data_ok the same cycle: go IDLE, drop data).
- DONE: stall=0 for exactly one cycle, load_data valid; -> IDLE unconditionally.
- CANCEL: wait for data_ok, discard data, -> IDLE. stall=dbus_en in this state.
- stall=1 in REQ and WAIT regardless of flush.
- Store alignment: mem_be = dbus_we << addr[1:0]; mem_wdata = SB {4{data[7:0]}}, SH {2{data[15:0]}}, SW data. mem_wr = |dbus_we.
- Load extension on byte lane addr[1:0]: LB/LBU sign/zero extend byte, LH/LHU halfword at addr[1], LW full word.

## Timing
- Minimum latency: request seen cycle 0, mem_req cycle 1, addr_ok cycle 1, data_ok cycle 2, DONE cycle 3 (stall high cycles 0-2).
- Zero-wait memory (addr_ok and data_ok in cycle 1): DONE in cycle 2.
- mem_* outputs are registered-stable from REQ entry until addr_ok; never change while mem_req=1.
- At most one outstanding transaction; a new request is accepted only in IDLE.
- rst mid-transaction returns to IDLE next edge; memory side is reset on the same rst.

## Configuration
- DBUS_ALIGN_CHECK_EN defined: adds outputs adel and ades (1 bit each). Misaligned SH/LH/LHU (addr[0]=1) or SW/LW (addr[1:0]!=0) in IDLE raises adel (load) or ades (store) combinationally, stall=0, no transaction issued.
- Not defined: no adel/ades ports; low address bits beyond the access size are ignored for lane selection.

## Structure
- State enum and oper constants (`OPER_LB/LBU/LH/LHU/LW/SB/SH/SW) live in defines.vh.
- One combinational sub-module: load_ext (oper, addr[1:0], rdata -> extended word).

## Test plan
- SB addr 0x1003 data 0x000000A5, addr_ok/data_ok cycle 1/2 -> mem_be 1000, mem_wdata 0xA5A5A5A5, mem_addr 0x1000, stall cycles 0-2.
- LB addr 0x2002, rdata 0x12F0_5678 -> load_data 0xFFFF_FFF0 in DONE; LBU same -> 0x0000_00F0.
- LH addr 0x2002 with addr_ok held low 5 cycles -> mem_req high 5 cycles, mem_* stable, load_data 0xFFFF_12F0? no: 0x0000_12F0 after data_ok.
- flush in WAIT, data_ok 3 cycles later -> CANCEL, load_data unchanged, IDLE after data_ok, next request accepted.
- rst in REQ -> next cycle IDLE, mem_req 0, stall 0.
- DBUS_ALIGN_CHECK_EN: SW addr 0x3002 -> ades=1, mem_req never asserted.
